// File: rtl/input_buffer_reader.sv
// input_buffer_reader
//
// Read sequencer placed directly after input_buffer. A start command sweeps a
// contiguous, wrapping address range on the buffer read port. The resulting
// words are streamed out on a valid/ready interface. The buffer has a one-cycle
// registered read latency. A small output FIFO absorbs that latency, and a
// credit check on the read enable keeps the FIFO from overflowing, so
// downstream backpressure never loses or duplicates a word.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   start        single-cycle command, accepted only while idle
//   base_addr    first buffer address, sampled when start is accepted
//   length       number of words, sampled when start is accepted (0 is legal)
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse when the burst completes
//   buf_rd_en    buffer read enable
//   buf_rd_addr  buffer read address
//   buf_rd_data  buffer read data, valid the cycle after buf_rd_en
//   m_valid      output word valid
//   m_ready      downstream accept
//   m_data       output word
//   m_last       marks the final word of a burst
module input_buffer_reader #(
    parameter int unsigned RD_DATA_WIDTH = 16,
    parameter int unsigned RD_ADDR_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [RD_ADDR_WIDTH-1:0]        base_addr,
    input  logic [RD_ADDR_WIDTH-1:0]        length,
    output logic                            busy,
    output logic                            done,
    output logic                            buf_rd_en,
    output logic [RD_ADDR_WIDTH-1:0]        buf_rd_addr,
    input  logic signed [RD_DATA_WIDTH-1:0] buf_rd_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic signed [RD_DATA_WIDTH-1:0] m_data,
    output logic                            m_last
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                   state_q, state_d;
    logic [RD_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RD_ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
    // Words still to be handed downstream; the head is the last word when this is 1.
    logic [RD_ADDR_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
    logic                     inflight_q;

    logic signed [RD_DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]                 count_q;
    logic                            fifo_push, fifo_pop, credit_ok;

    // A read issued last cycle still needs a FIFO slot; pops this cycle are not credited.
    assign credit_ok = (count_q + CntW'(inflight_q)) < CntW'(FIFO_DEPTH);
    assign fifo_push = inflight_q;
    assign m_valid   = (count_q != '0);
    assign fifo_pop  = m_valid & m_ready;
    assign m_data    = m_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign m_last    = m_valid && (drain_cnt_q == RD_ADDR_WIDTH'(1));

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign buf_rd_addr = addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        drain_cnt_d = drain_cnt_q;
        buf_rd_en   = 1'b0;

        if (fifo_pop) begin
            drain_cnt_d = drain_cnt_q - RD_ADDR_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StIssue;
                        addr_d      = base_addr;
                        issue_cnt_d = length;
                        drain_cnt_d = length;
                    end
                end
            end
            StIssue: begin
                if (credit_ok) begin
                    buf_rd_en   = 1'b1;
                    addr_d      = addr_q + RD_ADDR_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q - RD_ADDR_WIDTH'(1);
                    if (issue_cnt_q == RD_ADDR_WIDTH'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (fifo_pop && (drain_cnt_q == RD_ADDR_WIDTH'(1))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            drain_cnt_q <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            inflight_q  <= buf_rd_en;
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(fifo_push) - CntW'(fifo_pop);
        end
    end

    // Storage only; validity is tracked by the pointers and count above.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= buf_rd_data;
        end
    end

endmodule

// File: tb/tb_input_buffer_reader.sv
module tb_input_buffer_reader;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW-1:0]        length;
    logic                 busy;
    logic                 done;
    logic                 buf_rd_en;
    logic [AW-1:0]        buf_rd_addr;
    logic signed [DW-1:0] buf_rd_data;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_data;
    logic                 m_last;

    input_buffer_reader #(
        .RD_DATA_WIDTH(DW),
        .RD_ADDR_WIDTH(AW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .buf_rd_en  (buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    // Buffer model: mem[a] = a + 10; data is garbage whenever rd_en was low.
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= DW'(int'(buf_rd_addr) + 10);
        else           buf_rd_data <= DW'($urandom);
    end

    int total = 0;
    int bad   = 0;

    // Occupancy model: words landed minus words taken, plus the read in flight.
    int occ  = 0;
    bit infl = 1'b0;
    bit p_valid, p_ready, p_rd_en, p_last, p_rst;
    logic signed [DW-1:0] p_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        p_valid = m_valid;
        p_ready = m_ready;
        p_rd_en = buf_rd_en;
        p_last  = m_last;
        p_data  = m_data;
        p_rst   = rst;
        @(negedge clk);
        if (p_rst) begin
            occ  = 0;
            infl = 1'b0;
        end else begin
            occ  = occ + int'(infl) - int'(p_valid && p_ready);
            infl = p_rd_en;
        end
        check("valid_vs_occupancy", 64'(m_valid), 64'(occ != 0));
        check("credit_bound", 64'(occ + int'(infl) <= DEPTH), 64'(1));
        if (buf_rd_en) begin
            check("rd_en_credit", 64'(occ + int'(infl) < DEPTH), 64'(1));
            check("rd_en_outside_issue", 64'(busy && !done), 64'(1));
        end
        if (p_valid && !p_ready && !p_rst) begin
            check("stall_valid", 64'(m_valid), 64'(1));
            check("stall_data", 64'(m_data), 64'(p_data));
            check("stall_last", 64'(m_last), 64'(p_last));
        end
    endtask

    // One burst against a queue of expected words; optional start pokes while busy.
    task automatic run_burst(input int b, input int l, input int pct, input bit poke,
                             output int n_words, output int first_v, output int last_v,
                             output int done_cyc);
        int exp_q[$];
        int dones;
        int rd_cnt;
        int cyc;
        dones    = 0;
        rd_cnt   = 0;
        n_words  = 0;
        first_v  = -1;
        last_v   = -1;
        done_cyc = -1;
        for (int i = 0; i < l; i++) exp_q.push_back(((b + i) % 16) + 10);
        base_addr = AW'(b);
        length    = AW'(l);
        start     = 1'b1;
        m_ready   = ($urandom_range(99) < pct);
        tick();
        cyc = 1;
        while (cyc < 400) begin
            m_ready   = ($urandom_range(99) < pct);
            start     = poke && busy && (done || $urandom_range(3) == 0);
            base_addr = AW'($urandom);
            length    = AW'($urandom_range(15, 1));
            if (cyc == 1) check("busy_after_start", 64'(busy), 64'(1));
            if (buf_rd_en) begin
                check("rd_addr", 64'(buf_rd_addr), 64'((b + rd_cnt) % 16));
                rd_cnt++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word: got %0d expected none", m_data);
                end else begin
                    check("word", 64'(m_data), 64'(exp_q[0]));
                    check("last", 64'(m_last), 64'(exp_q.size() == 1));
                    if (first_v < 0) first_v = int'(m_data);
                    last_v = int'(m_data);
                    void'(exp_q.pop_front());
                    n_words++;
                end
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("idle_after_done", 64'(busy), 64'(0));
                break;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL burst_timeout: got no done expected done within 400 cycles");
        end
        check("done_pulses", 64'(dones), 64'(1));
        check("read_count", 64'(rd_cnt), 64'(l));
    endtask

    typedef struct {
        int base;
        int len;
        int pct;
        bit poke;
        int exp_words;
        int exp_first;
        int exp_last;
        int exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nw, fv, lv, dc;

        vecs[0] = '{0, 4, 100, 1'b0, 4, 10, 13, 7};
        vecs[1] = '{14, 4, 100, 1'b0, 4, 24, 11, 7};
        vecs[2] = '{0, 8, 50, 1'b0, 8, 10, 17, -1};
        vecs[3] = '{3, 0, 100, 1'b0, 0, -1, -1, 1};
        vecs[4] = '{5, 6, 40, 1'b1, 6, 15, 20, -1};
        vecs[5] = '{15, 1, 100, 1'b1, 1, 25, 25, 4};
        vecs[6] = '{0, 15, 70, 1'b1, 15, 10, 24, -1};
        vecs[7] = '{10, 8, 100, 1'b1, 8, 20, 11, 11};

        rst       = 1'b1;
        start     = 1'b0;
        m_ready   = 1'b0;
        base_addr = '0;
        length    = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rd_en", 64'(buf_rd_en), 64'(0));
        check("rst_rd_addr", 64'(buf_rd_addr), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        rst = 1'b0;
        tick();

        // Cycle-exact basic burst: base 0, length 4, always ready.
        base_addr = '0;
        length    = AW'(4);
        start     = 1'b1;
        m_ready   = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            check("basic_rd_en", 64'(buf_rd_en), 64'(cyc >= 1 && cyc <= 4));
            if (cyc <= 4) check("basic_rd_addr", 64'(buf_rd_addr), 64'(cyc - 1));
            check("basic_m_valid", 64'(m_valid), 64'(cyc >= 3 && cyc <= 6));
            if (cyc >= 3 && cyc <= 6) check("basic_m_data", 64'(m_data), 64'(cyc + 7));
            check("basic_m_last", 64'(m_last), 64'(cyc == 6));
            check("basic_done", 64'(done), 64'(cyc == 7));
            check("basic_busy", 64'(busy), 64'(cyc <= 7));
            tick();
        end

        // Reset in the middle of a burst.
        base_addr = '0;
        length    = AW'(8);
        start     = 1'b1;
        m_ready   = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 4; cyc++) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_rd_en", 64'(buf_rd_en), 64'(0));
        check("mid_rst_rd_addr", 64'(buf_rd_addr), 64'(0));
        check("mid_rst_m_valid", 64'(m_valid), 64'(0));
        check("mid_rst_m_data", 64'(m_data), 64'(0));
        check("mid_rst_m_last", 64'(m_last), 64'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_rd_en", 64'(buf_rd_en), 64'(0));
            check("post_rst_m_valid", 64'(m_valid), 64'(0));
        end
        run_burst(0, 3, 100, 1'b0, nw, fv, lv, dc);
        check("post_rst_first", 64'(fv), 64'(10));
        check("post_rst_words", 64'(nw), 64'(3));

        for (int v = 0; v < 8; v++) begin
            run_burst(vecs[v].base, vecs[v].len, vecs[v].pct, vecs[v].poke, nw, fv, lv, dc);
            check($sformatf("vec%0d_words", v), 64'(nw), 64'(vecs[v].exp_words));
            check($sformatf("vec%0d_first", v), 64'(fv), 64'(vecs[v].exp_first));
            check($sformatf("vec%0d_last", v), 64'(lv), 64'(vecs[v].exp_last));
            if (vecs[v].exp_done >= 0) begin
                check($sformatf("vec%0d_done_cyc", v), 64'(dc), 64'(vecs[v].exp_done));
            end
        end

        for (int r = 0; r < 25; r++) begin
            int rb, rl, rp;
            rb = $urandom_range(15);
            rl = $urandom_range(15);
            rp = $urandom_range(100, 15);
            run_burst(rb, rl, rp, 1'($urandom_range(1)), nw, fv, lv, dc);
            check("rand_words", 64'(nw), 64'(rl));
            if (rl > 0) check("rand_first", 64'(fv), 64'((rb % 16) + 10));
            if (rp == 100) check("rand_done_cyc", 64'(dc), 64'(rl == 0 ? 1 : rl + 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
